yutorina_bus_arbiter: RTL and testbench
=======================================

// Module: yutorina_bus_arbiter
// PURPOSE
//  Round-robin arbiter granting the shared system bus to one of N bus masters.
//  Masters: IF-stage and MEM-stage bus interfaces of each core, plus any DMA.
//  Sits between the masters' req_/grnt_ handshake and the bus address/data mux.
//  Drives owner select and the bus-busy indication.
// PARAMETERS
//  N_MASTERS       4    number of requesters; 2..8
//  TIMEOUT_CYCLES  255  max consecutive granted cycles; used only with BUS_ARB_TIMEOUT_EN
// PORTS
//  clk          in   1              system clock; all logic on rising edge
//  rst          in   1              synchronous, active-high reset
//  req_         in   N_MASTERS      per-master bus request, active-low
//  grnt_        out  N_MASTERS      per-master bus grant, active-low, registered, one-hot-low
//  owner        out  clog2(N)       index of current/last owner; drives bus mux select
//  bus_busy     out  1              high while any grant is asserted
//  arb_timeout  out  1              1-cycle pulse when a grant is revoked by the watchdog
// BEHAVIOUR
//  - Reset (rst=1 at an edge): grnt_ all 1, owner=0, bus_busy=0, arb_timeout=0,
//    state=IDLE, counter=0. Reset mid-grant drops the grant at that same edge.
//  - States:
//    - IDLE: no grant held.
//    - GRANT: exactly one grnt_ bit low.
//  - IDLE, any req_ low: pick the first requester scanning owner+1, owner+2, ...
//    wrapping mod N, ending with owner itself.
//    - Next edge: that grnt_ goes low, owner updates, state=GRANT.
//    - Latency: req_ low at edge k -> grnt_ low after edge k.
//  - IDLE, all req_ high: stay IDLE; owner unchanged.
//  - GRANT: grant held while owner's req_ stays low. Other requests are ignored;
//    no preemption.
//  - GRANT, owner's req_ high (release):
//    - If another req_ is low, grant the next winner at the same edge (scan from
//      owner+1). There is no dead cycle, but grnt_ moves from one bit to another
//      atomically.
//    - If no other req_ is low: all grnt_ go high and state=IDLE.
//  - A request withdrawn before its grant is simply not granted; a master must
//    hold req_ low until it sees grnt_ low.
//  - Simultaneous requests: rotating priority only; no master starves. Worst-case
//    wait is (N-1) tenures.
//  - bus_busy == (state==GRANT), registered alongside grnt_.
//  - owner width = $clog2(N_MASTERS). owner keeps its value in IDLE so rotation
//    resumes from the last owner.
// CONFIGURATION
//  Macro BUS_ARB_TIMEOUT_EN.
//  - Defined:
//    - A counter clears on every new grant and increments each GRANT cycle.
//    - When counter == TIMEOUT_CYCLES-1 and owner still requests, the grant is
//      revoked at the next edge.
//    - That edge: arb_timeout pulses 1 for one cycle and the winner is re-picked
//      from owner+1. The offender re-enters the rotation last.
//    - Release on the same edge as expiry counts as a normal release; no pulse.
//  - Undefined: no counter; grants are held indefinitely; arb_timeout tied 0.
//    Port list is identical in both builds.
// STRUCTURE
//  - bus.h:
//    - BUS_MASTER_MAX, BUS_OWNER_BUS width macro.
//    - Arbiter state encodings BUS_ARB_STATE_IDLE / BUS_ARB_STATE_GRANT.
//    - TIMEOUT default.
//  - stddef.h: ENABLE_/DISABLE_ active-low level macros.
//  - Sub-module yutorina_rr_pick: combinational rotating-priority picker.
//    - Inputs: request vector (active-high), last owner.
//    - Outputs: valid, winner index.
//    - Used for both IDLE pick and release hand-off.
// TESTING
//  1. Reset then all req_=1 -> grnt_=4'b1111, bus_busy=0, owner=0 for 10 cycles.
//  2. Single requester: req_[2]=0 at edge k -> grnt_=4'b1011 after k, owner=2.
//     req_[2]=1 -> grnt_=4'b1111 next edge.
//  3. All four request, owner=0, each releases after 3 cycles -> grant order
//     1,2,3,0, back-to-back with no idle cycle between tenures.
//  4. Master 1 holds grant while 0,3 request -> no preemption.
//     On release, grant goes to 3 (scan from 2), then 0.
//  5. Reset asserted mid-grant of master 3 -> grnt_=4'b1111, owner=0 at that edge.
//     After reset, first pick scans from 1.
//  6. With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: master 0 holds req_ low
//     indefinitely, master 1 requests.
//     -> Grant revoked after 8 cycles, arb_timeout=1 for 1 cycle, grnt_=4'b1101.
//     Without the macro, master 0 keeps the grant for 100+ cycles and
//     arb_timeout stays 0.

Source files
------------

// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: limits, active-low levels,
// arbiter state encoding and the owner-index width helper.
package yutorina_bus_arbiter_pkg;

  localparam int unsigned BUS_MASTER_MAX      = 8;
  localparam int unsigned BUS_TIMEOUT_DEFAULT = 255;

  // Active-low request/grant levels
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic {
    BUS_ARB_STATE_IDLE,
    BUS_ARB_STATE_GRANT
  } bus_arb_state_e;

  function automatic int unsigned bus_owner_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/yutorina_rr_pick.sv
// Combinational rotating-priority picker: first active request scanning
// last+1, last+2, ... wrapping mod N and ending with last itself.
module yutorina_rr_pick
  import yutorina_bus_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = bus_owner_bits(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] winner
);

  logic [W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid  = 1'b0;
    winner = last;
    cand   = '0;
    for (int unsigned off = N; off >= 1; off--) begin
      cand = W'((32'(last) + off) % N);
      if (req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Round-robin bus arbiter with active-low req_/grnt_ handshake, owner select and
// bus-busy flag. Optional grant watchdog enabled by macro BUS_ARB_TIMEOUT_EN.
module yutorina_bus_arbiter
  import yutorina_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_MASTERS-1:0]                 req_,
  output logic [N_MASTERS-1:0]                 grnt_,
  output logic [bus_owner_bits(N_MASTERS)-1:0] owner,
  output logic                                 bus_busy,
  output logic                                 arb_timeout
);

  localparam int unsigned W = bus_owner_bits(N_MASTERS);

  if (N_MASTERS < 2 || N_MASTERS > BUS_MASTER_MAX || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("yutorina_bus_arbiter: unsupported N_MASTERS or TIMEOUT_CYCLES");
  end

  bus_arb_state_e         state;
  logic [N_MASTERS-1:0]   req;
  logic                   owner_req;
  logic                   pick_valid;
  logic [W-1:0]           pick_winner;
  logic [N_MASTERS-1:0]   grant_mask;

  assign req       = ~req_;
  assign owner_req = req[owner];

  yutorina_rr_pick #(
    .N (N_MASTERS),
    .W (W)
  ) u_pick (
    .req    (req),
    .last   (owner),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    grant_mask              = {N_MASTERS{DISABLE_}};
    grant_mask[pick_winner] = ENABLE_;
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned     CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0]              hold_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BUS_ARB_STATE_IDLE;
      grnt_       <= '1;
      owner       <= '0;
      bus_busy    <= 1'b0;
      arb_timeout <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt    <= '0;
`endif
    end else begin
      arb_timeout <= 1'b0;
      case (state)
        BUS_ARB_STATE_IDLE: begin
          if (pick_valid) begin
            state    <= BUS_ARB_STATE_GRANT;
            grnt_    <= grant_mask;
            owner    <= pick_winner;
            bus_busy <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        BUS_ARB_STATE_GRANT: begin
          // The owner's own request is inactive on release, so the scan from
          // owner+1 never picks it; on expiry it stays eligible but comes last.
          if (!owner_req) begin
            if (pick_valid) begin
              grnt_ <= grant_mask;
              owner <= pick_winner;
            end else begin
              state    <= BUS_ARB_STATE_IDLE;
              grnt_    <= '1;
              bus_busy <= 1'b0;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            arb_timeout <= 1'b1;
            grnt_       <= grant_mask;
            owner       <= pick_winner;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Scoreboard bench for yutorina_bus_arbiter: a tenure-level reference model pushes
// the expected outputs per edge; a monitor pops and compares one entry per cycle.
module tb_yutorina_bus_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_;
  logic [N-1:0] grnt_;
  logic [1:0]   owner;
  logic         bus_busy;
  logic         arb_timeout;

  yutorina_bus_arbiter #(
    .N_MASTERS      (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_        (req_),
    .grnt_       (grnt_),
    .owner       (owner),
    .bus_busy    (bus_busy),
    .arb_timeout (arb_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic [1:0]   o;
    logic         b;
    logic         t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who holds the bus, who owned it last, how long the tenure is.
  int           m_holder = -1;
  int           m_owner  = 0;
  int           m_tenure = 0;
  bit           m_to     = 0;

  // Master behaviour: requesting flag and remaining held cycles once granted.
  logic [N-1:0] want_v = '0;
  int           left[N];

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++) begin
      int idx = (last + off) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [N-1:0] want);
    int   p;
    exp_t e;
    if (r) begin
      m_holder = -1; m_owner = 0; m_tenure = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_holder < 0) begin
        p = pick(want, m_owner);
        if (p >= 0) begin m_holder = p; m_owner = p; m_tenure = 1; end
      end else if (!want[m_holder]) begin
        p = pick(want, m_owner);
        m_holder = p;
        if (p >= 0) begin m_owner = p; m_tenure = 1; end
        else m_tenure = 0;
      end else if (TO_EN && m_tenure == TMO) begin
        m_to = 1;
        p = pick(want, m_owner);
        m_holder = p; m_owner = p; m_tenure = 1;
      end else begin
        m_tenure++;
      end
    end
    e.g = '1;
    if (m_holder >= 0) e.g[m_holder] = 1'b0;
    e.o = 2'(m_owner);
    e.b = (m_holder >= 0);
    e.t = m_to;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r);
    rst  = r;
    req_ = ~want_v;
    model_edge(r, want_v);
    @(posedge clk);
    #2;
  endtask

  task automatic update_masters(input bit allow_new);
    for (int i = 0; i < N; i++) begin
      if (m_holder == i) begin
        if (left[i] == 0) want_v[i] = 1'b0;
        else left[i]--;
      end else if (want_v[i]) begin
        if (allow_new && $urandom_range(0, 24) == 0) want_v[i] = 1'b0;
      end else if (allow_new && $urandom_range(0, 2) == 0) begin
        want_v[i] = 1'b1;
        left[i]   = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({grnt_, owner, bus_busy, arb_timeout} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got grnt_=%b owner=%0d busy=%b timeout=%b required grnt_=%b owner=%0d busy=%b timeout=%b",
                   $time, grnt_, owner, bus_busy, arb_timeout, e.g, e.o, e.b, e.t);
        end
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < N; i++) left[i] = 0;
    // Reset, then idle bus
    want_v = '0;
    repeat (2) step(1'b1);
    repeat (10) step(1'b0);
    // Single requester on master 2, then release
    want_v = 4'b0100;
    repeat (3) step(1'b0);
    want_v = '0;
    repeat (2) step(1'b0);
    // All four request, each holds for three cycles
    want_v = '1;
    for (int i = 0; i < N; i++) left[i] = 2;
    repeat (16) begin step(1'b0); update_masters(1'b0); end
    // Master 0 holds indefinitely while master 1 waits
    want_v = 4'b0001;
    left[0] = 1000;
    step(1'b0); update_masters(1'b0);
    want_v[1] = 1'b1;
    left[1]   = 1;
    repeat (30) begin step(1'b0); update_masters(1'b0); end
    want_v[0] = 1'b0;
    repeat (6) begin step(1'b0); update_masters(1'b0); end
    // Random traffic with a mid-run reset
    for (int c = 0; c < 400; c++) begin
      step((c == 200) ? 1'b1 : 1'b0);
      update_masters(1'b1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
